// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: bus widths, arbiter state encoding and
// the pixel-pair word layout used by the scan controller and image loader.
package fb_pkg;

  localparam int FB_DATA_WIDTH = 48;
  localparam int FB_ADDR_WIDTH = 15;
  localparam int STARVE_CNT_W  = 8;

  // Operation issued to the RAM in the current cycle.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_t;

  // Pixel-pair word: pixel 0 in the low 24 bits, pixel 1 above it;
  // within a pixel the channels run B (low byte), G, R (high byte).
  localparam int PIX_BITS = 24;
  localparam int CH_BITS  = 8;
  localparam int PIX0_LSB = 0;
  localparam int PIX1_LSB = 24;
  localparam int CH_B_OFS = 0;
  localparam int CH_G_OFS = 8;
  localparam int CH_R_OFS = 16;

  function automatic logic [FB_DATA_WIDTH-1:0] pack_pixel_pair(
    input logic [PIX_BITS-1:0] pix0,
    input logic [PIX_BITS-1:0] pix1
  );
    return {pix1, pix0};
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Requester and RAM-side signal bundle of the frame-buffer arbiter.
// slave = arbiter side, master = requesters plus RAM macro.
interface fb_arbiter_if
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
);

  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_gnt;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_req;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_gnt;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt, ram_addr, ram_wdata, ram_we, starve_cnt
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, ram_addr, ram_wdata, ram_we, starve_cnt
  );

endinterface

// File: rtl/fb_arb_grant.sv
// Combinational grant decision: reads win unless a starved write is forced.
// The forced-write rule exists only when FB_ARB_STARVE_EN is defined.
module fb_arb_grant
  import fb_pkg::*;
#(
  parameter int WR_STARVE_MAX = 8
) (
  input  logic                    rd_req,
  input  logic                    wr_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    rd_gnt,
  output logic                    wr_gnt
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(WR_STARVE_MAX);

  logic force_wr;

`ifdef FB_ARB_STARVE_EN
  assign force_wr = wr_req && (starve_cnt >= STARVE_MAX);
`else
  // Strict read priority: the count and threshold have no effect here.
  logic unused_starve;
  assign unused_starve = ^{starve_cnt, STARVE_MAX};
  assign force_wr      = 1'b0;
`endif

  always_comb begin
    // NOTE: both outputs get a default before any branch, so no path leaves
    // them unassigned and no latch is inferred.
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (force_wr)    wr_gnt = 1'b1;
    else if (rd_req) rd_gnt = 1'b1;
    else if (wr_req) wr_gnt = 1'b1;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer RAM arbiter: read priority with a bounded write
// starvation interval (define FB_ARB_STARVE_EN to enable forced writes).
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int WR_STARVE_MAX = 8
) (
  input logic         clk_in,
  input logic         rst,
  fb_arbiter_if.slave bus
);

  arb_state_t              state;
  arb_state_t              state_next;
  logic                    rd_gnt_raw;
  logic                    wr_gnt_raw;
  logic                    rd_gnt;
  logic                    wr_gnt;
  logic                    rd_valid_q;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  fb_arb_grant #(
    .WR_STARVE_MAX(WR_STARVE_MAX)
  ) u_grant (
    .rd_req    (bus.rd_req),
    .wr_req    (bus.wr_req),
    .starve_cnt(starve_cnt),
    .rd_gnt    (rd_gnt_raw),
    .wr_gnt    (wr_gnt_raw)
  );

  // Nothing is granted while reset is held, so no transfer is lost silently.
  assign rd_gnt = rd_gnt_raw & ~rst;
  assign wr_gnt = wr_gnt_raw & ~rst;

  always_comb begin
    state_next = ARB_IDLE;
    if (rd_gnt)      state_next = ARB_RD;
    else if (wr_gnt) state_next = ARB_WR;
  end

  // NOTE: clocked blocks use non-blocking assignments so every register
  // samples the values present before the edge, independent of block order.
  always_ff @(posedge clk_in) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // The state register doubles as the RAM command stage: ARB_RD marks the
  // first rd_valid stage, ARB_WR is the registered write enable.
  always_ff @(posedge clk_in) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= (state == ARB_RD);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else if (rd_gnt) begin
      bus.ram_addr  <= bus.rd_addr;
    end else if (wr_gnt) begin
      bus.ram_addr  <= bus.wr_addr;
      bus.ram_wdata <= bus.wr_data;
    end
  end

`ifdef FB_ARB_STARVE_EN
  always_ff @(posedge clk_in) begin
    if (rst || !bus.wr_req || wr_gnt)      starve_cnt <= '0;
    else if (starve_cnt != '1)             starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve_cnt = '0;
`endif

  assign bus.ram_we     = (state == ARB_WR);
  assign bus.rd_gnt     = rd_gnt;
  assign bus.wr_gnt     = wr_gnt;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = bus.ram_rdata;
  assign bus.starve_cnt = starve_cnt;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a history-based model of the grant rules.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int DW         = FB_DATA_WIDTH;
  localparam int AW         = FB_ADDR_WIDTH;
  localparam int MAXC       = 2000;
  localparam int STARVE_MAX = 8;
`ifdef FB_ARB_STARVE_EN
  localparam bit STARVE_ON  = 1'b1;
`else
  localparam bit STARVE_ON  = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  fb_arbiter_if bus ();

  fb_arbiter #(.WR_STARVE_MAX(STARVE_MAX)) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM macro model (driven by the DUT's RAM port) ----------
  logic [DW-1:0] ram [int];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} + 1'b1;
  endfunction

  always @(posedge clk_in) begin
    if ($isunknown(bus.ram_addr)) begin
      bus.ram_rdata <= '0;
    end else begin
      bus.ram_rdata <= ram.exists(int'(bus.ram_addr)) ? ram[int'(bus.ram_addr)]
                                                      : init_word(bus.ram_addr);
      if (bus.ram_we === 1'b1) ram[int'(bus.ram_addr)] = bus.ram_wdata;
    end
  end

  // ---------------- Reference model: per-cycle history -------------------
  typedef struct {
    bit            rst;
    bit            rd_req;
    bit            wr_req;
    bit            rd_g;
    bit            wr_g;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
  } cyc_t;

  cyc_t          hist      [MAXC];
  logic [DW-1:0] exp_rdata [MAXC];
  logic [DW-1:0] ref_mem   [int];

  // Consecutive refused write-request cycles immediately before cycle c.
  function automatic int exp_starve(input int c);
    int n = 0;
    if (!STARVE_ON) return 0;
    for (int k = c - 1; k >= 0; k--) begin
      if (hist[k].rst || !hist[k].wr_req || hist[k].wr_g) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [1:0] exp_grant(input int c);
    if (hist[c].rst) return 2'b00;
    if (STARVE_ON && hist[c].wr_req && exp_starve(c) >= STARVE_MAX) return 2'b01;
    if (hist[c].rd_req) return 2'b10;
    if (hist[c].wr_req) return 2'b01;
    return 2'b00;
  endfunction

  // RAM address = address of the most recent grant since the last reset.
  function automatic logic [AW-1:0] exp_ram_addr(input int c);
    for (int k = c - 1; k >= 0; k--) begin
      if (hist[k].rst)  return '0;
      if (hist[k].rd_g) return hist[k].rd_addr;
      if (hist[k].wr_g) return hist[k].wr_addr;
    end
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_ram_wdata(input int c);
    for (int k = c - 1; k >= 0; k--) begin
      if (hist[k].rst)  return '0;
      if (hist[k].wr_g) return hist[k].wr_data;
    end
    return '0;
  endfunction

  function automatic bit exp_ram_we(input int c);
    return (c >= 1) && hist[c-1].wr_g;
  endfunction

  function automatic bit exp_rd_valid(input int c);
    return (c >= 2) && hist[c-2].rd_g && !hist[c-1].rst;
  endfunction

  function automatic logic [DW-1:0] ref_lookup(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  // Cycle boundary: apply the write the model says landed this cycle and
  // capture what a read addressed this cycle returns next cycle.
  always @(posedge clk_in) begin
    if (cyc >= 1 && cyc < MAXC - 1) begin
      exp_rdata[cyc+1] = ref_lookup(exp_ram_addr(cyc));
      if (exp_ram_we(cyc)) ref_mem[int'(exp_ram_addr(cyc))] = exp_ram_wdata(cyc);
    end
    cyc = cyc + 1;
  end

  // Compare process: every cycle from the first post-reset-edge cycle on.
  always @(negedge clk_in) begin
    int         c;
    logic [1:0] g;
    c = cyc;
    if (c >= 0 && c < MAXC) begin
      hist[c].rst     = rst;
      hist[c].rd_req  = bus.rd_req;
      hist[c].wr_req  = bus.wr_req;
      hist[c].rd_addr = bus.rd_addr;
      hist[c].wr_addr = bus.wr_addr;
      hist[c].wr_data = bus.wr_data;
      g               = exp_grant(c);
      hist[c].rd_g    = g[1];
      hist[c].wr_g    = g[0];
      if (c >= 1) begin
        check("m_rd_gnt",     bus.rd_gnt,     g[1]);
        check("m_wr_gnt",     bus.wr_gnt,     g[0]);
        check("m_ram_we",     bus.ram_we,     exp_ram_we(c));
        check("m_ram_addr",   bus.ram_addr,   exp_ram_addr(c));
        check("m_ram_wdata",  bus.ram_wdata,  exp_ram_wdata(c));
        check("m_starve_cnt", bus.starve_cnt, exp_starve(c));
        check("m_rd_valid",   bus.rd_valid,   exp_rd_valid(c));
        if (exp_rd_valid(c)) check("m_rd_data", bus.rd_data, exp_rdata[c]);
      end
    end
  end

  // ---------------- Directed stimulus -------------------------------------
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    repeat (n) next_cycle();
  endtask

  logic rg = 1'b0;
  logic wg = 1'b0;

  initial begin
    bus.rd_req  = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    rst         = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk_in);
    check("reset_rd_gnt",     bus.rd_gnt,     0);
    check("reset_ram_we",     bus.ram_we,     0);
    check("reset_ram_addr",   bus.ram_addr,   0);
    check("reset_starve_cnt", bus.starve_cnt, 0);
    next_cycle();
    rst = 1'b0;
    idle(3);

    // Read only: four back-to-back reads of 0..3, RAM returns addr+1.
    for (int i = 0; i < 7; i++) begin
      bus.rd_req  = (i < 4);
      bus.rd_addr = AW'((i < 4) ? i : 0);
      @(negedge clk_in);
      if (i < 4) check("s1_rd_gnt", bus.rd_gnt, 1);
      check("s1_rd_valid", bus.rd_valid, (i >= 2 && i < 6));
      if (i >= 2 && i < 6) check("s1_rd_data", bus.rd_data, i - 1);
      next_cycle();
    end
    idle(2);

    // Write in an idle cycle, then read it back.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h0400;
    bus.wr_data = 48'hABCDEF123456;
    @(negedge clk_in);
    check("s2_wr_gnt", bus.wr_gnt, 1);
    check("s2_we_before", bus.ram_we, 0);
    next_cycle();
    bus.wr_req = 1'b0;
    @(negedge clk_in);
    check("s2_ram_we", bus.ram_we, 1);
    check("s2_ram_addr", bus.ram_addr, 15'h0400);
    check("s2_ram_wdata", bus.ram_wdata, 48'hABCDEF123456);
    next_cycle();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 15'h0400;
    @(negedge clk_in);
    check("s2_we_one_cycle", bus.ram_we, 0);
    check("s2_rd_gnt", bus.rd_gnt, 1);
    next_cycle();
    bus.rd_req = 1'b0;
    next_cycle();
    @(negedge clk_in);
    check("s2_readback_valid", bus.rd_valid, 1);
    check("s2_readback_data", bus.rd_data, 48'hABCDEF123456);
    next_cycle();
    idle(2);

    // Starvation: continuous reads with a write pending from cycle 0.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 15'h0020;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h0030;
    bus.wr_data = 48'h000011112222;
`ifdef FB_ARB_STARVE_EN
    for (int k = 0; k < 10; k++) begin
      if (k == 9) bus.wr_req = 1'b0;
      @(negedge clk_in);
      check("s3_rd_gnt", bus.rd_gnt, (k != 8));
      check("s3_wr_gnt", bus.wr_gnt, (k == 8));
      check("s3_starve_cnt", bus.starve_cnt, (k == 9) ? 0 : k);
      next_cycle();
    end
`else
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      check("s3_wr_gnt_blocked", bus.wr_gnt, 0);
      next_cycle();
    end
    bus.rd_req = 1'b0;
    @(negedge clk_in);
    check("s3_wr_gnt_on_rd_drop", bus.wr_gnt, 1);
    check("s3_starve_cnt_tied", bus.starve_cnt, 0);
    next_cycle();
`endif
    idle(3);

    // Collision: write 0x0010 at N, read 0x0010 at N+1, new data at N+3.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h0010;
    bus.wr_data = 48'h555555555555;
    @(negedge clk_in);
    check("s4_wr_gnt", bus.wr_gnt, 1);
    next_cycle();
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 15'h0010;
    @(negedge clk_in);
    check("s4_rd_gnt", bus.rd_gnt, 1);
    next_cycle();
    bus.rd_req = 1'b0;
    next_cycle();
    @(negedge clk_in);
    check("s4_rd_valid", bus.rd_valid, 1);
    check("s4_rd_data", bus.rd_data, 48'h555555555555);
    next_cycle();
    idle(2);

    // Reset mid-read: the in-flight read is dropped.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 15'h0005;
    @(negedge clk_in);
    check("s5_rd_gnt", bus.rd_gnt, 1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk_in);
    check("s5_no_gnt_in_reset", bus.rd_gnt, 0);
    next_cycle();
    rst        = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clk_in);
    check("s5_rd_valid", bus.rd_valid, 0);
    check("s5_ram_we", bus.ram_we, 0);
    check("s5_starve_cnt", bus.starve_cnt, 0);
    next_cycle();
    idle(2);

    // Mixed traffic obeying the hold-until-grant handshake; one reset pulse.
    for (int i = 0; i < 300; i++) begin
      rst = (i == 150);
      if (!bus.rd_req || rg) begin
        bus.rd_req  = ($urandom_range(0, 3) != 0);
        bus.rd_addr = AW'($urandom_range(0, 63));
      end
      if (!bus.wr_req || wg) begin
        bus.wr_req  = ($urandom_range(0, 1) != 0);
        bus.wr_addr = AW'($urandom_range(0, 63));
        bus.wr_data = DW'({$urandom, $urandom});
      end
      @(negedge clk_in);
      rg = bus.rd_gnt;
      wg = bus.wr_gnt;
      next_cycle();
    end
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Arbiter sequencing a single-port synchronous frame-buffer RAM (48-bit pixel pairs, 15-bit address) shared between the LED scan controller (reader) and the image loader (writer). Reads have priority so panel refresh never stalls. Writes are granted in idle cycles, or forced after a bounded starvation interval. Sits between the RAM macro and both requesters, on the scan clock domain.

## Interface
- DATA_WIDTH, 48, pixel-pair word width (2 × RGB × 8 bit)
- ADDR_WIDTH, 15, RAM word address width
- WR_STARVE_MAX, 8, consecutive refused write-request cycles before a write is forced (1..255)

- clk_in  in  1  scan clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  reader requests one word
- rd_addr  in  ADDR_WIDTH  read address, stable while rd_req high
- rd_gnt  out  1  read accepted this cycle
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DATA_WIDTH  read word
- wr_req  in  1  writer requests one word write
- wr_addr  in  ADDR_WIDTH  write address, stable while wr_req high
- wr_data  in  DATA_WIDTH  write word, stable while wr_req high
- wr_gnt  out  1  write accepted this cycle
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_wdata  out  DATA_WIDTH  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data, 1 cycle after address
- starve_cnt  out  8  current write-starvation count, for debug

## Operation
- Per-cycle grant decision (combinational from rd_req, wr_req, starve_cnt):
  - Force write: wr_req & starve_cnt ≥ WR_STARVE_MAX → wr_gnt=1, rd_gnt=0.
  - Otherwise, rd_req → rd_gnt=1.
  - Otherwise, wr_req → wr_gnt=1.
  - At most one grant per cycle.
- State register records the operation issued to the RAM this cycle:
  - IDLE: no grant last cycle.
  - RD: read issued.
  - WR: write issued.
  - Next state = RD / WR / IDLE from that cycle's grant.
- Granted read: ram_addr←rd_addr, ram_we←0.
- Granted write: ram_addr←wr_addr, ram_wdata←wr_data, ram_we←1.
- No grant: ram_we←0; ram_addr and ram_wdata hold their values.
- rd_data = ram_rdata, passed through combinationally. rd_valid is a 2-stage delay of rd_gnt.
- starve_cnt:
  - Increments (saturating at 255) when wr_req=1 and wr_gnt=0.
  - Clears on wr_gnt, or when wr_req=0.
- Handshake:
  - Requester holds req, addr and data until it sees gnt.
  - Each gnt cycle consumes one transfer.
  - Keeping req high after gnt issues the next transfer (back-to-back allowed, one per cycle).
- Same-address read and write in flight: RAM order equals grant order. A read granted after a write returns the new data.

## Timing
- Reset values: rd_gnt=0, wr_gnt=0, rd_valid=0, rd_data follows ram_rdata, ram_addr=0, ram_wdata=0, ram_we=0, starve_cnt=0, state=IDLE.
- Read latency: rd_gnt in cycle N → ram_addr driven cycle N+1 → rd_valid=1 and rd_data valid cycle N+2.
- Write latency: wr_gnt in cycle N → ram_we=1 cycle N+1, for exactly one cycle per grant.
- Throughput: 1 transfer/cycle total.
- Worst-case write wait under continuous reads: WR_STARVE_MAX+1 cycles from wr_req rise to wr_gnt.
- A forced write delays the pending read by exactly 1 cycle. The reader must tolerate rd_gnt gaps.
- Reset mid-operation: in-flight reads are dropped (rd_valid pipeline cleared), pending ram_we is cleared, and no grant is issued in the reset cycle.

## Configuration
- FB_ARB_STARVE_EN defined: starvation counter and forced-write rule active as above.
- FB_ARB_STARVE_EN undefined:
  - Strict read priority; writes are granted only when rd_req=0.
  - starve_cnt is tied to 0 and the counter logic is removed.

## Structure
- Shared package fb_pkg holds:
  - FB_DATA_WIDTH=48 and FB_ADDR_WIDTH=15.
  - The state enum (ARB_IDLE, ARB_RD, ARB_WR).
  - The pixel-pair field offsets used by the scan controller and loader.
- One sub-module, fb_arb_grant: the combinational priority/starvation grant logic. The top level holds the state, RAM output registers, rd_valid pipeline and counter.

## Test plan
- Read only: rd_req held 4 cycles, addrs 0x0000..0x0003, RAM model returns addr+1 → rd_gnt 4 cycles, rd_valid cycles N+2..N+5, rd_data 1,2,3,4.
- Write idle: wr_req, wr_addr=0x0400, wr_data=0xABCDEF123456, rd_req=0 → wr_gnt same cycle, ram_we=1 next cycle only, readback returns 0xABCDEF123456.
- Starvation (macro on, WR_STARVE_MAX=8): rd_req continuous, wr_req from cycle 0 → wr_gnt at cycle 8, rd_gnt=0 only at cycle 8, starve_cnt then 0.
- Starvation (macro off): same stimulus for 50 cycles → wr_gnt never asserts. It asserts in the first cycle rd_req drops.
- Collision: write 0x55.. to addr 0x0010 granted cycle N, read 0x0010 granted N+1 → rd_data=0x55.. at N+3.
- Reset mid-read: rd_gnt at N, rst at N+1 → rd_valid stays 0, ram_we=0, starve_cnt=0 at N+2.
